// File: rtl/port_mailbox.sv
// CPU port mailbox: toggle-handshaked TX/RX byte FIFOs between the CPU
// port bus (s0..s3 / e0..e3) and an external valid/ready byte stream.
module port_mailbox #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic [7:0] s3,
  output logic [7:0] e0,
  output logic [7:0] e1,
  output logic [7:0] e2,
  output logic [7:0] e3,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_cnt, rx_cnt, tx_cnt_nxt, rx_cnt_nxt;
  logic          tx_ack, rx_ack, flush_ack;
  logic          flush_pend, tx_push, tx_pop, rx_push, rx_pop;
  logic          unused_ok;

  assign unused_ok = ^{s0[7:3], s2, s3};

  // Flush wins over every push/pop in the same cycle.
  assign flush_pend = s0[2] != flush_ack;
  assign tx_pop     = tx_valid & tx_ready & ~flush_pend;
  assign tx_push    = (s0[0] != tx_ack) & ((tx_cnt != FULL) | tx_pop) & ~flush_pend;
  assign rx_push    = rx_valid & rx_ready & ~flush_pend;
  assign rx_pop     = (s0[1] != rx_ack) & (rx_cnt != '0) & ~flush_pend;

  always_comb begin
    tx_cnt_nxt = tx_cnt;
    rx_cnt_nxt = rx_cnt;
    if (tx_push && !tx_pop) tx_cnt_nxt = tx_cnt + CW'(1);
    if (!tx_push && tx_pop) tx_cnt_nxt = tx_cnt - CW'(1);
    if (rx_push && !rx_pop) rx_cnt_nxt = rx_cnt + CW'(1);
    if (!rx_push && rx_pop) rx_cnt_nxt = rx_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr     <= '0;
      tx_rd     <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      tx_ack    <= 1'b0;
      rx_ack    <= 1'b0;
      flush_ack <= 1'b0;
    end else if (flush_pend) begin
      tx_wr     <= '0;
      tx_rd     <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      flush_ack <= s0[2];
    end else begin
      if (tx_push) begin
        tx_wr  <= tx_wr + AW'(1);
        tx_ack <= s0[0];
      end
      if (tx_pop) tx_rd <= tx_rd + AW'(1);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop) begin
        rx_rd  <= rx_rd + AW'(1);
        rx_ack <= s0[1];
      end
      tx_cnt <= tx_cnt_nxt;
      rx_cnt <= rx_cnt_nxt;
    end
  end

  // Storage needs no reset; counts gate every read.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= s1;
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  assign tx_valid = tx_cnt != '0;
  assign tx_data  = tx_valid ? tx_mem[tx_rd] : 8'h00;
  assign rx_ready = rx_cnt != FULL;
  assign e0       = {3'b000, rx_cnt != '0, tx_cnt == FULL, flush_ack, rx_ack, tx_ack};
  assign e1       = (rx_cnt != '0) ? rx_mem[rx_rd] : 8'h00;
  assign e2       = 8'(tx_cnt);
  assign e3       = 8'(rx_cnt);

endmodule

// File: tb/tb_port_mailbox.sv
// Directed self-checking bench for port_mailbox.
module tb_port_mailbox;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s0, s1, s2, s3;
  logic [7:0] e0, e1, e2, e3;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  int         checks = 0;
  int         errors = 0;

  port_mailbox #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .e0(e0), .e1(e1), .e2(e2), .e3(e3),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; s0 = 8'h00; s1 = 8'h00; s2 = 8'h00; s3 = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #22;
    chk("reset_e0", 32'(e0), 32'h00);
    chk("reset_e2", 32'(e2), 32'h00);
    chk("reset_rx_ready", 32'(rx_ready), 32'h1);
    reset = 1'b1;
    step();
    chk("idle_e0", 32'(e0), 32'h00);
    chk("idle_e1", 32'(e1), 32'h00);
    chk("idle_e3", 32'(e3), 32'h00);
    chk("idle_tx_valid", 32'(tx_valid), 32'h0);
    chk("idle_tx_data", 32'(tx_data), 32'h00);

    // Single TX byte, then external pop.
    s1 = 8'hA5; s0[0] = 1'b1;
    step();
    chk("tx1_e0", 32'(e0), 32'h01);
    chk("tx1_e2", 32'(e2), 32'h1);
    chk("tx1_valid", 32'(tx_valid), 32'h1);
    chk("tx1_data", 32'(tx_data), 32'hA5);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("tx1_pop_e2", 32'(e2), 32'h0);
    chk("tx1_pop_valid", 32'(tx_valid), 32'h0);

    // Fill TX, then a 9th byte waits for space that opens on a pop.
    for (int i = 1; i <= 8; i++) begin
      s1 = 8'(i); s0[0] = ~s0[0];
      step();
    end
    chk("txfull_e0", 32'(e0), 32'h09);
    chk("txfull_e2", 32'(e2), 32'h8);
    chk("txfull_head", 32'(tx_data), 32'h01);
    s1 = 8'h09; s0[0] = ~s0[0];
    step();
    chk("tx9_withheld_e0", 32'(e0), 32'h09);
    chk("tx9_withheld_e2", 32'(e2), 32'h8);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("tx9_accept_e0", 32'(e0), 32'h08);
    chk("tx9_accept_e2", 32'(e2), 32'h8);
    tx_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk("tx_drain_data", 32'(tx_data), 32'(k));
      step();
    end
    tx_ready = 1'b0;
    chk("tx_drain_e2", 32'(e2), 32'h0);
    chk("tx_drain_valid", 32'(tx_valid), 32'h0);

    // RX pop requested while empty waits for a byte.
    s0[1] = 1'b1;
    step();
    chk("rxwait_e0", 32'(e0), 32'h00);
    rx_data = 8'h3C; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    chk("rxwait_push_e1", 32'(e1), 32'h3C);
    chk("rxwait_push_e3", 32'(e3), 32'h1);
    chk("rxwait_push_e0", 32'(e0), 32'h10);
    step();
    chk("rxwait_pop_e0", 32'(e0), 32'h02);
    chk("rxwait_pop_e3", 32'(e3), 32'h0);
    chk("rxwait_pop_e1", 32'(e1), 32'h00);

    // Fill RX, then pop and offer a byte on the full edge.
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h10 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    chk("rxfull_ready", 32'(rx_ready), 32'h0);
    chk("rxfull_e3", 32'(e3), 32'h8);
    chk("rxfull_e1", 32'(e1), 32'h10);
    rx_data = 8'hFF; rx_valid = 1'b1; s0[1] = ~s0[1];
    step();
    chk("rxfull_pop_e3", 32'(e3), 32'h7);
    chk("rxfull_pop_e1", 32'(e1), 32'h11);
    chk("rxfull_pop_e0", 32'(e0), 32'h10);
    chk("rxfull_pop_ready", 32'(rx_ready), 32'h1);
    step();
    rx_valid = 1'b0;
    chk("rxfull_ff_e3", 32'(e3), 32'h8);
    for (int i = 0; i < 6; i++) begin
      chk("rx_pop_seq_e1", 32'(e1), 32'h11 + 32'(i));
      s0[1] = ~s0[1];
      step();
    end
    chk("rx_two_e3", 32'(e3), 32'h2);
    chk("rx_two_e1", 32'(e1), 32'h17);

    // Flush with a concurrent TX request; the request lands one edge later.
    for (int i = 1; i <= 3; i++) begin
      s1 = 8'hA0 + 8'(i); s0[0] = ~s0[0];
      step();
    end
    chk("preflush_e2", 32'(e2), 32'h3);
    chk("preflush_e0", 32'(e0), 32'h11);
    s1 = 8'h55; s0[0] = ~s0[0]; s0[2] = 1'b1;
    step();
    chk("flush_e2", 32'(e2), 32'h0);
    chk("flush_e3", 32'(e3), 32'h0);
    chk("flush_e0", 32'(e0), 32'h05);
    step();
    chk("postflush_e2", 32'(e2), 32'h1);
    chk("postflush_data", 32'(tx_data), 32'h55);
    chk("postflush_e0", 32'(e0), 32'h04);

    // Asynchronous reset mid-stream.
    rx_data = 8'h77; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("areset_e0", 32'(e0), 32'h00);
    chk("areset_e1", 32'(e1), 32'h00);
    chk("areset_e2", 32'(e2), 32'h00);
    chk("areset_e3", 32'(e3), 32'h00);
    chk("areset_tx_valid", 32'(tx_valid), 32'h0);
    chk("areset_tx_data", 32'(tx_data), 32'h00);
    chk("areset_rx_ready", 32'(rx_ready), 32'h1);
    s0 = 8'h00;
    #3;
    reset = 1'b1;
    step();
    s1 = 8'hA5; s0[0] = 1'b1;
    step();
    chk("rst_tx_e0", 32'(e0), 32'h01);
    chk("rst_tx_e2", 32'(e2), 32'h1);
    chk("rst_tx_data", 32'(tx_data), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
